// File: rtl/reg_xfer_pkg.sv
// Shared types and default sizing for the register-file transfer sequencer.
package reg_xfer_pkg;

  localparam int DEF_DW      = 16;
  localparam int DEF_NREG    = 8;
  localparam int DEF_AW      = 3;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    EXEC  = 2'd2,
    WRITE = 2'd3
  } xfer_state_t;

endpackage

// File: rtl/onehot_dec.sv
// Address-to-one-hot decoder; produces all zeros when disabled or when the
// address does not name an existing register.
module onehot_dec #(
  parameter int AW   = 3,
  parameter int NREG = 8
) (
  input  logic [AW-1:0]   addr,
  input  logic            en,
  output logic [NREG-1:0] onehot
);

  // Compare against every valid index so out-of-range addresses decode to zero.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-file transfer sequencer: reads two registers onto the A/B buses,
// hands the operands to the ALU, waits for the result and writes it back.
//
// state | meaning
// IDLE  | ready for a request; bad addresses are rejected here with err
// READ  | oe_a/oe_b asserted, buses captured into op_a/op_b at cycle end
// EXEC  | op_valid high, waiting for res_valid or timeout
// WRITE | load[dst] asserted with wb_data stable
module reg_xfer_ctrl
  import reg_xfer_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int NREG    = DEF_NREG,
  parameter int AW      = DEF_AW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [AW-1:0]   req_src_a,
  input  logic [AW-1:0]   req_src_b,
  input  logic [AW-1:0]   req_dst,
  input  logic            req_wr,
  output logic [NREG-1:0] oe_a,
  output logic [NREG-1:0] oe_b,
  output logic [NREG-1:0] load,
  input  logic [DW-1:0]   bus_a,
  input  logic [DW-1:0]   bus_b,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            op_valid,
  input  logic            res_valid,
  input  logic [DW-1:0]   res_data,
  output logic [DW-1:0]   wb_data,
  output logic            err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  xfer_state_t state_q, state_d;

  logic [AW-1:0]   dst_q;
  logic            wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            accept, addr_ok, res_hit, timeout_hit;
  logic            oe_en, ld_en, op_valid_d, err_d, capture_ops;
  logic [NREG-1:0] oe_a_d, oe_b_d, load_d;

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid && req_ready;
  assign addr_ok     = (32'(req_src_a) < NREG) && (32'(req_src_b) < NREG) &&
                       (32'(req_dst) < NREG);
  assign res_hit     = (state_q == EXEC) && res_valid;
  // res_valid wins over the timeout even on the last allowed EXEC cycle.
  assign timeout_hit = (state_q == EXEC) && !res_valid && (cnt_q == CW'(TIMEOUT - 1));

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && addr_ok) state_d = READ;
      READ:    state_d = EXEC;
      EXEC: begin
        if (res_valid)        state_d = wr_q ? WRITE : IDLE;
        else if (timeout_hit) state_d = IDLE;
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered strobes, flags and timeout counter.
  always_comb begin
    oe_en       = accept && addr_ok;
    ld_en       = res_hit && wr_q;
    op_valid_d  = (state_d == EXEC);
    err_d       = (accept && !addr_ok) || timeout_hit;
    capture_ops = (state_q == READ);
    cnt_d       = '0;
    if (state_q == EXEC && state_d == EXEC) cnt_d = cnt_q + CW'(1);
  end

  onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_oe_a (
    .addr   (req_src_a),
    .en     (oe_en),
    .onehot (oe_a_d)
  );

  onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_oe_b (
    .addr   (req_src_b),
    .en     (oe_en),
    .onehot (oe_b_d)
  );

  onehot_dec #(.AW(AW), .NREG(NREG)) u_dec_load (
    .addr   (dst_q),
    .en     (ld_en),
    .onehot (load_d)
  );

  // Registered strobes and datapath; async reset drops every strobe at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      oe_a     <= '0;
      oe_b     <= '0;
      load     <= '0;
      op_valid <= 1'b0;
      err      <= 1'b0;
      cnt_q    <= '0;
      dst_q    <= '0;
      wr_q     <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      wb_data  <= '0;
    end else begin
      oe_a     <= oe_a_d;
      oe_b     <= oe_b_d;
      load     <= load_d;
      op_valid <= op_valid_d;
      err      <= err_d;
      cnt_q    <= cnt_d;
      if (oe_en) begin
        dst_q <= req_dst;
        wr_q  <= req_wr;
      end
      if (capture_ops) begin
        op_a <= bus_a;
        op_b <= bus_b;
      end
      if (res_hit) wb_data <= res_data;
    end
  end

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Directed bench for reg_xfer_ctrl with a behavioural register bank.
module tb_reg_xfer_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n;
  logic        req_valid, req_ready, req_wr;
  logic [2:0]  req_src_a, req_src_b, req_dst;
  logic [7:0]  oe_a, oe_b, load;
  logic [15:0] bus_a, bus_b, op_a, op_b, res_data, wb_data;
  logic        op_valid, res_valid, err;

  // Second instance with a bank of 6 so addresses 6/7 are out of range.
  logic        req_valid_6, req_ready_6, req_wr_6;
  logic [2:0]  req_src_a_6, req_src_b_6, req_dst_6;
  logic [5:0]  oe_a_6, oe_b_6, load_6;
  logic [15:0] bus_a_6, bus_b_6, op_a_6, op_b_6, res_data_6, wb_data_6;
  logic        op_valid_6, res_valid_6, err_6;

  reg_xfer_ctrl dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src_a(req_src_a), .req_src_b(req_src_b), .req_dst(req_dst), .req_wr(req_wr),
    .oe_a(oe_a), .oe_b(oe_b), .load(load),
    .bus_a(bus_a), .bus_b(bus_b), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .res_valid(res_valid), .res_data(res_data), .wb_data(wb_data), .err(err)
  );

  reg_xfer_ctrl #(.NREG(6)) dut6 (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid_6), .req_ready(req_ready_6),
    .req_src_a(req_src_a_6), .req_src_b(req_src_b_6), .req_dst(req_dst_6), .req_wr(req_wr_6),
    .oe_a(oe_a_6), .oe_b(oe_b_6), .load(load_6),
    .bus_a(bus_a_6), .bus_b(bus_b_6), .op_a(op_a_6), .op_b(op_b_6), .op_valid(op_valid_6),
    .res_valid(res_valid_6), .res_data(res_data_6), .wb_data(wb_data_6), .err(err_6)
  );

  // Register bank model: preload while bank_rst, otherwise write on load.
  logic        bank_rst;
  logic [15:0] regs [8];

  always @(posedge clock) begin
    if (bank_rst) begin
      regs[0] <= 16'hA5A5; regs[1] <= 16'h1111; regs[2] <= 16'h1234; regs[3] <= 16'h0001;
      regs[4] <= 16'h8000; regs[5] <= 16'h00FF; regs[6] <= 16'h0F0F; regs[7] <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) if (load[i]) regs[i] <= wb_data;
    end
  end

  always_comb begin
    bus_a = '0;
    bus_b = '0;
    for (int i = 0; i < 8; i++) begin
      if (oe_a[i]) bus_a = bus_a | regs[i];
      if (oe_b[i]) bus_b = bus_b | regs[i];
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]  src_a, src_b, dst;
    logic        wr;
    int          delay;
    logic [15:0] res;
    logic [7:0]  exp_oe_a, exp_oe_b;
    logic [15:0] exp_op_a, exp_op_b;
    logic [7:0]  exp_load;
    logic [15:0] exp_wb;
  } vec_t;

  vec_t vecs[5];

  // Accept in cycle 0, oe in cycle 1, op_valid from cycle 2, result after delay.
  task automatic run_vec(input vec_t v, input int idx);
    check($sformatf("v%0d_ready_in", idx), 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_src_a = v.src_a; req_src_b = v.src_b;
    req_dst = v.dst; req_wr = v.wr;
    step();
    req_valid = 1'b0;
    check($sformatf("v%0d_oe_a", idx), 32'(oe_a), 32'(v.exp_oe_a));
    check($sformatf("v%0d_oe_b", idx), 32'(oe_b), 32'(v.exp_oe_b));
    check($sformatf("v%0d_busy", idx), 32'(req_ready), 32'd0);
    step();
    check($sformatf("v%0d_op_a", idx), 32'(op_a), 32'(v.exp_op_a));
    check($sformatf("v%0d_op_b", idx), 32'(op_b), 32'(v.exp_op_b));
    check($sformatf("v%0d_op_valid", idx), 32'(op_valid), 32'd1);
    check($sformatf("v%0d_oe_off", idx), 32'({oe_a, oe_b}), 32'd0);
    for (int i = 0; i < v.delay; i++) step();
    res_valid = 1'b1; res_data = v.res;
    step();
    res_valid = 1'b0; res_data = '0;
    check($sformatf("v%0d_load", idx), 32'(load), 32'(v.exp_load));
    check($sformatf("v%0d_wb_data", idx), 32'(wb_data), 32'(v.exp_wb));
    check($sformatf("v%0d_op_valid_off", idx), 32'(op_valid), 32'd0);
    check($sformatf("v%0d_err", idx), 32'(err), 32'd0);
    if (v.wr) begin
      step();
      check($sformatf("v%0d_load_off", idx), 32'(load), 32'd0);
    end
    check($sformatf("v%0d_ready_out", idx), 32'(req_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic bad_ov, bad_err, load_seen;

    //       a     b     dst   wr    dly  res        oe_a   oe_b   op_a       op_b       load   wb
    vecs[0] = '{3'd2, 3'd5, 3'd7, 1'b1, 0,  16'h1333, 8'h04, 8'h20, 16'h1234, 16'h00FF, 8'h80, 16'h1333};
    vecs[1] = '{3'd3, 3'd3, 3'd3, 1'b1, 0,  16'h0002, 8'h08, 8'h08, 16'h0001, 16'h0001, 8'h08, 16'h0002};
    vecs[2] = '{3'd7, 3'd3, 3'd0, 1'b0, 2,  16'hBEEF, 8'h80, 8'h08, 16'h1333, 16'h0002, 8'h00, 16'hBEEF};
    vecs[3] = '{3'd0, 3'd6, 3'd1, 1'b1, 14, 16'hFFFF, 8'h01, 8'h40, 16'hA5A5, 16'h0F0F, 8'h02, 16'hFFFF};
    vecs[4] = '{3'd1, 3'd4, 3'd1, 1'b1, 1,  16'h7FFF, 8'h02, 8'h10, 16'hFFFF, 16'h8000, 8'h02, 16'h7FFF};

    reset_n = 1'b0; bank_rst = 1'b1;
    req_valid = 0; req_src_a = 0; req_src_b = 0; req_dst = 0; req_wr = 0;
    res_valid = 0; res_data = 0;
    req_valid_6 = 0; req_src_a_6 = 0; req_src_b_6 = 0; req_dst_6 = 0; req_wr_6 = 0;
    res_valid_6 = 0; res_data_6 = 0; bus_a_6 = 0; bus_b_6 = 0;

    step(); step();
    check("rst_strobes", 32'({oe_a, oe_b, load}), 32'd0);
    check("rst_op_valid", 32'(op_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    reset_n = 1'b1; bank_rst = 1'b0;
    step();
    check("rst_ready_after", 32'(req_ready), 32'd1);

    // Back-to-back: each vector starts in the IDLE cycle the previous one ends in.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    check("bank_r7", 32'(regs[7]), 32'h1333);
    check("bank_r3", 32'(regs[3]), 32'h0002);
    check("bank_r0_nowrite", 32'(regs[0]), 32'hA5A5);
    check("bank_r1", 32'(regs[1]), 32'h7FFF);

    // Timeout: 15 EXEC cycles without res_valid, err in the cycle after.
    req_valid = 1'b1; req_src_a = 3'd2; req_src_b = 3'd5; req_dst = 3'd4; req_wr = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    bad_ov = 1'b0; bad_err = 1'b0; load_seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      if (op_valid !== 1'b1) bad_ov = 1'b1;
      if (err !== 1'b0) bad_err = 1'b1;
      if (load !== '0) load_seen = 1'b1;
      step();
    end
    check("to_op_valid_held", 32'(bad_ov), 32'd0);
    check("to_no_early_err", 32'(bad_err), 32'd0);
    check("to_err_pulse", 32'(err), 32'd1);
    check("to_op_valid_drop", 32'(op_valid), 32'd0);
    check("to_ready", 32'(req_ready), 32'd1);
    // res_valid while idle must be ignored.
    res_valid = 1'b1; res_data = 16'hDEAD;
    step();
    res_valid = 1'b0; res_data = '0;
    if (load !== '0) load_seen = 1'b1;
    check("to_err_clear", 32'(err), 32'd0);
    check("to_no_load", 32'(load_seen), 32'd0);
    check("idle_res_ignored", 32'(wb_data), 32'h7FFF);
    check("to_bank_r4", 32'(regs[4]), 32'h8000);

    // Reset mid-EXEC.
    req_valid = 1'b1; req_src_a = 3'd0; req_src_b = 3'd1; req_dst = 3'd2; req_wr = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    check("mid_exec_op_valid", 32'(op_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_exec_rst_op_valid", 32'(op_valid), 32'd0);
    check("mid_exec_rst_strobes", 32'({oe_a, oe_b, load}), 32'd0);
    check("mid_exec_rst_op_a", 32'(op_a), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("mid_exec_ready", 32'(req_ready), 32'd1);

    // Reset during READ drops the enables without waiting for a clock.
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    check("read_oe_a", 32'(oe_a), 32'h01);
    #2 reset_n = 1'b0;
    #1;
    check("read_rst_oe", 32'({oe_a, oe_b}), 32'd0);
    step();
    reset_n = 1'b1;
    step();
    check("read_rst_ready", 32'(req_ready), 32'd1);

    // Out-of-range addresses on the 6-register instance.
    req_valid_6 = 1'b1; req_src_a_6 = 3'd7; req_src_b_6 = 3'd1; req_dst_6 = 3'd2; req_wr_6 = 1'b1;
    step();
    req_valid_6 = 1'b0;
    check("bad_a_err", 32'(err_6), 32'd1);
    check("bad_a_strobes", 32'({oe_a_6, oe_b_6, load_6}), 32'd0);
    check("bad_a_ready", 32'(req_ready_6), 32'd1);
    step();
    check("bad_a_err_clear", 32'(err_6), 32'd0);
    req_valid_6 = 1'b1; req_src_a_6 = 3'd0; req_src_b_6 = 3'd1; req_dst_6 = 3'd6;
    step();
    req_valid_6 = 1'b0;
    check("bad_dst_err", 32'(err_6), 32'd1);
    check("bad_dst_strobes", 32'({oe_a_6, oe_b_6, load_6}), 32'd0);
    step();
    req_valid_6 = 1'b1; req_src_a_6 = 3'd5; req_src_b_6 = 3'd0; req_dst_6 = 3'd1;
    step();
    req_valid_6 = 1'b0;
    check("n6_top_oe_a", 32'(oe_a_6), 32'h20);
    check("n6_oe_b", 32'(oe_b_6), 32'h01);
    check("n6_no_err", 32'(err_6), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
